// File: rtl/cond_unit.sv
// cond_unit: conditional-execution unit sitting after the ALU.
// Holds the NZCV flags register, evaluates each instruction's condition field
// against the flags left by earlier instructions, gates the PC/register/memory
// write strobes with the result and selectively updates the flags. The output
// side is a single registered slot with a valid/ready handshake.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = ~out_valid | out_ready)
//   Cond                  condition field
//   ALUFlags              ALU flags {N,Z,C,V}
//   FlagW                 [1] write N,Z  [0] write C,V
//   PCS, RegW, MemW       raw write strobes
//   NoWrite               compare-class: suppress register write
//   flush                 squash output slot and current input
//   out_valid / out_ready output handshake
//   CondEx, PCSrc, RegWrite, MemWrite  registered results
//   Flags                 current flags register {N,Z,C,V}
//   squash_count          failed-condition counter
//
// Optional feature: define COND_UNIT_PERF_EN to build the saturating
// squash_count counter; otherwise squash_count is tied to zero.
module cond_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        NoWrite,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        CondEx,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [3:0]  Flags,
  output logic [31:0] squash_count
);

  logic [3:0] flags_q, flags_d;
  logic       out_valid_q, out_valid_d;
  logic       cond_ex_q, cond_ex_d;
  logic       pc_src_q, pc_src_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;
  logic accept;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  // Condition is judged against the registered flags, never this ALUFlags.
  always_comb begin
    cond_pass = 1'b0;
    unique case (Cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    cond_ex_d   = cond_ex_q;
    pc_src_d    = pc_src_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      cond_ex_d   = cond_pass;
      pc_src_d    = PCS & cond_pass;
      reg_write_d = RegW & ~NoWrite & cond_pass;
      mem_write_d = MemW & cond_pass;
      if (cond_pass && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (cond_pass && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      cond_ex_q   <= cond_ex_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
    end
  end

`ifdef COND_UNIT_PERF_EN
  logic [31:0] squash_q, squash_d;

  // Saturating count of accepted instructions whose condition failed.
  always_comb begin
    squash_d = squash_q;
    if (accept && !cond_pass && (squash_q != 32'hFFFF_FFFF)) begin
      squash_d = squash_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      squash_q <= 32'd0;
    end else begin
      squash_q <= squash_d;
    end
  end

  assign squash_count = squash_q;
`else
  assign squash_count = 32'd0;
`endif

  assign out_valid = out_valid_q;
  assign CondEx    = cond_ex_q;
  assign PCSrc     = pc_src_q;
  assign RegWrite  = reg_write_q;
  assign MemWrite  = mem_write_q;
  assign Flags     = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit.
module tb_cond_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS, RegW, MemW, NoWrite;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0]  Flags;
  logic [31:0] squash_count;

  int checks   = 0;
  int failures = 0;
  int exp_sq   = 0;

`ifdef COND_UNIT_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  cond_unit dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Cond         (Cond),
    .ALUFlags     (ALUFlags),
    .FlagW        (FlagW),
    .PCS          (PCS),
    .RegW         (RegW),
    .MemW         (MemW),
    .NoWrite      (NoWrite),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .CondEx       (CondEx),
    .PCSrc        (PCSrc),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .Flags        (Flags),
    .squash_count (squash_count)
  );

  always #5 clk = ~clk;

  // Sample and drive 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: flags f = {N,Z,C,V}.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 0; Cond = 4'hE; ALUFlags = 0; FlagW = 0;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; flush = 0;
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic pcs, input logic rw, input logic mw, input logic nw);
    in_valid = 1; Cond = c; FlagW = fw; ALUFlags = af;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
  endtask

  task automatic check_sq(input string name);
    logic [31:0] exp;
    exp = Perf ? 32'(exp_sq) : 32'd0;
    checks++;
    if (squash_count !== exp) begin
      failures++;
      $display("FAIL %s squash_count got=%0h exp=%0h", name, squash_count, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1;
    reset = 1;
    step(); step();
    reset = 0;
    exp_sq = 0;
    checks++;
    if ({out_valid, CondEx, PCSrc, RegWrite, MemWrite} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=00000",
               {out_valid, CondEx, PCSrc, RegWrite, MemWrite});
    end
    checks++;
    if (Flags !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", Flags);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    check_sq("reset");
  endtask

  task automatic test_basic();
    drive(4'hE, 2'b11, 4'b0100, 0, 1, 0, 0);
    step();
    idle_inputs();
    checks++;
    if ({out_valid, CondEx, RegWrite, PCSrc, MemWrite} !== 5'b11100) begin
      failures++;
      $display("FAIL basic_outs got=%b exp=11100",
               {out_valid, CondEx, RegWrite, PCSrc, MemWrite});
    end
    checks++;
    if (Flags !== 4'b0100) begin
      failures++; $display("FAIL basic_flags got=%b exp=0100", Flags);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    // Flags = 0100 (Z set): EQ passes, NE fails.
    drive(4'h0, 2'b00, 4'b0000, 0, 0, 1, 0);
    step();
    drive(4'h1, 2'b00, 4'b0000, 0, 0, 1, 0);
    checks++;
    if ({out_valid, CondEx, MemWrite} !== 3'b111) begin
      failures++; $display("FAIL b2b_eq got=%b exp=111", {out_valid, CondEx, MemWrite});
    end
    step();
    idle_inputs();
    exp_sq++;
    checks++;
    if ({out_valid, CondEx, MemWrite} !== 3'b100) begin
      failures++; $display("FAIL b2b_ne got=%b exp=100", {out_valid, CondEx, MemWrite});
    end
    check_sq("b2b");
    step();
  endtask

  task automatic test_flag_halves();
    drive(4'hE, 2'b11, 4'b1111, 0, 0, 0, 0);
    step();
    drive(4'hE, 2'b10, 4'b0000, 0, 0, 0, 0);
    checks++;
    if (Flags !== 4'b1111) begin
      failures++; $display("FAIL halves_all got=%b exp=1111", Flags);
    end
    step();
    // GE with N=0,V=1 fails; its FlagW must not take effect.
    drive(4'hA, 2'b11, 4'b1010, 0, 1, 0, 0);
    checks++;
    if (Flags !== 4'b0011) begin
      failures++; $display("FAIL halves_nz got=%b exp=0011", Flags);
    end
    step();
    exp_sq++;
    // Compare-class instruction: condition passes, register write suppressed.
    drive(4'hE, 2'b00, 4'b0000, 0, 1, 0, 1);
    checks++;
    if ({out_valid, CondEx, RegWrite} !== 3'b100) begin
      failures++; $display("FAIL halves_ge got=%b exp=100", {out_valid, CondEx, RegWrite});
    end
    checks++;
    if (Flags !== 4'b0011) begin
      failures++; $display("FAIL halves_hold got=%b exp=0011", Flags);
    end
    step();
    idle_inputs();
    checks++;
    if ({CondEx, RegWrite} !== 2'b10) begin
      failures++; $display("FAIL nowrite got=%b exp=10", {CondEx, RegWrite});
    end
    check_sq("halves");
    step();
  endtask

  task automatic test_stall();
    drive(4'hE, 2'b00, 4'b0000, 1, 0, 0, 0);
    step();
    out_ready = 0;
    drive(4'hE, 2'b11, 4'b1000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({in_ready, out_valid, PCSrc, Flags} !== 7'b0110011) begin
        failures++;
        $display("FAIL stall_%0d got=%b exp=0110011", i, {in_ready, out_valid, PCSrc, Flags});
      end
      step();
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release got=%b exp=1", in_ready);
    end
    step();
    idle_inputs();
    checks++;
    if ({out_valid, PCSrc, Flags} !== 6'b101000) begin
      failures++; $display("FAIL stall_accept got=%b exp=101000", {out_valid, PCSrc, Flags});
    end
  endtask

  task automatic test_flush();
    // Output slot holds a valid result; flush drops it and the new input.
    drive(4'hE, 2'b11, 4'b0100, 0, 0, 0, 0);
    flush = 1;
    step();
    idle_inputs();
    checks++;
    if ({out_valid, Flags} !== 5'b01000) begin
      failures++; $display("FAIL flush got=%b exp=01000", {out_valid, Flags});
    end
    // Flush of a failing instruction must not count it.
    drive(4'hF, 2'b00, 4'b0000, 0, 0, 0, 0);
    flush = 1;
    step();
    idle_inputs();
    check_sq("flush");
  endtask

  task automatic test_sweep();
    logic exp;
    for (int f = 0; f < 16; f++) begin
      drive(4'hE, 2'b11, 4'(f), 0, 0, 0, 0);
      step();
      for (int c = 0; c < 16; c++) begin
        drive(4'(c), 2'b00, 4'b0000, 1, 1, 1, 0);
        step();
        exp = ref_cond(4'(c), 4'(f));
        if (!exp) exp_sq++;
        checks++;
        if ({out_valid, CondEx, PCSrc, RegWrite, MemWrite} !== {1'b1, {4{exp}}}) begin
          failures++;
          $display("FAIL sweep cond=%h flags=%h got=%b exp=%b", c, f,
                   {out_valid, CondEx, PCSrc, RegWrite, MemWrite}, {1'b1, {4{exp}}});
        end
      end
    end
    idle_inputs();
    step();
    check_sq("sweep");
  endtask

  task automatic test_reset_mid_stall();
    drive(4'hE, 2'b11, 4'b1111, 0, 1, 0, 0);
    step();
    out_ready = 0;
    flush = 1;
    reset = 1;
    step();
    reset = 0;
    idle_inputs();
    out_ready = 1;
    exp_sq = 0;
    checks++;
    if ({out_valid, RegWrite, Flags} !== 6'b000000) begin
      failures++; $display("FAIL reset_stall got=%b exp=000000", {out_valid, RegWrite, Flags});
    end
    check_sq("reset_stall");
  endtask

`ifdef COND_UNIT_PERF_EN
  task automatic test_saturation();
    force dut.squash_q = 32'hFFFF_FFFE;
    step();
    release dut.squash_q;
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, 2'b00, 4'b0000, 0, 0, 0, 0);
      step();
    end
    idle_inputs();
    checks++;
    if (squash_count !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL saturate got=%0h exp=ffffffff", squash_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flag_halves();
    test_stall();
    test_flush();
    test_sweep();
    test_reset_mid_stall();
`ifdef COND_UNIT_PERF_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
